// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester, sweep and regfile-write signals.
// master = requesters/display side, slave = arbiter.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [4*NUM_REQ-1:0]  req_addr;
  logic [14*NUM_REQ-1:0] req_data;
  logic                  sweep_busy;
  logic [NUM_REQ-1:0]    req_ack;
  logic [NUM_REQ-1:0]    req_err;
  logic [18:0]           write_data_1;
  logic [1:0]            grant_id;

  modport master (
    output req_valid, req_addr, req_data,
    output sweep_busy,
    input  req_ack, req_err,
    input  write_data_1, grant_id
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    input  sweep_busy,
    output req_ack, req_err,
    output write_data_1, grant_id
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the card-regfile write port.
// Ports: clk, rst (async active-low), bus (slave modport).
// Option: REGFILE_ARB_FIXED_PRIORITY_EN -> fixed priority, else RR.
module regfile_write_arbiter #(
  parameter int NUM_REQ          = 3,
  parameter int NUM_CARDS        = 12,
  parameter int FIRST_CARD_INDEX = 1
) (
  input logic clk,
  input logic rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  typedef logic [IW-1:0] idx_t;

  localparam logic [4:0] ADDR_LO =
    5'(FIRST_CARD_INDEX);
  localparam logic [4:0] ADDR_HI =
    5'(FIRST_CARD_INDEX + NUM_CARDS - 1);

  logic [3:0]  addr_a [NUM_REQ];
  logic [13:0] data_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g] = bus.req_addr[4*g +: 4];
    assign data_a[g] = bus.req_data[14*g +: 14];
  end

  logic [18:0]        wd_q, wd_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [1:0]         gid_q, gid_d;
`ifndef REGFILE_ARB_FIXED_PRIORITY_EN
  idx_t               rr_q, rr_d;
`endif

  idx_t               cand;
  idx_t               gnt_idx;
  logic               found;
  logic               accept;
  logic               legal;
  logic [3:0]         sel_addr;
  logic [13:0]        sel_data;
  logic [NUM_REQ-1:0] ack;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
      cand = idx_t'(k);
`else
      cand = idx_t'((int'(rr_q) + k + 1) % NUM_REQ);
`endif
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // ack is forced low while reset is held
  assign accept   = found & ~bus.sweep_busy & rst;
  assign sel_addr = addr_a[gnt_idx];
  assign sel_data = data_a[gnt_idx];
  assign legal    = ({1'b0, sel_addr} >= ADDR_LO) &&
                    ({1'b0, sel_addr} <= ADDR_HI);

  always_comb begin
    ack = '0;
    if (accept) ack[gnt_idx] = 1'b1;
  end

  // illegal addresses are still acked so no requester deadlocks
  always_comb begin
    wd_d  = '0;
    err_d = '0;
    gid_d = gid_q;
`ifndef REGFILE_ARB_FIXED_PRIORITY_EN
    rr_d  = rr_q;
`endif
    if (accept) begin
      gid_d = 2'(gnt_idx);
`ifndef REGFILE_ARB_FIXED_PRIORITY_EN
      rr_d  = gnt_idx;
`endif
      if (legal) wd_d = {sel_data, sel_addr, 1'b1};
      else       err_d[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= '0;
      gid_q <= '0;
`ifndef REGFILE_ARB_FIXED_PRIORITY_EN
      rr_q  <= idx_t'(NUM_REQ - 1);
`endif
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
      gid_q <= gid_d;
`ifndef REGFILE_ARB_FIXED_PRIORITY_EN
      rr_q  <= rr_d;
`endif
    end
  end

  assign bus.req_ack      = ack;
  assign bus.req_err      = err_q;
  assign bus.write_data_1 = wd_q;
  assign bus.grant_id     = gid_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scenario tasks plus a randomized run
// checked against a rule-level arbitration model.
module tb_regfile_write_arbiter;
  logic clk;
  logic rst;

  regfile_write_arbiter_if #(.NUM_REQ(3)) bus();

  regfile_write_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  logic [2:0]  r_val;
  logic [3:0]  r_addr [3];
  logic [13:0] r_data [3];
  logic        sweep;

  int          m_last;
  int          m_acc;
  logic [18:0] e_wd;
  logic [2:0]  e_err;
  logic [1:0]  e_gid;

  // winner: valid requester closest after the last grant
  // (or lowest index in the fixed-priority build)
  function automatic int pick(logic [2:0] v, int last);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = 99;
    for (int i = 0; i < 3; i++) begin
`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
      d = i;
`else
      d = (i - last - 1 + 6) % 3;
`endif
      if (v[i] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  function automatic logic [2:0] onehot(int i);
    logic [2:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_last = 2;
    m_acc  = -1;
    e_wd   = '0;
    e_err  = '0;
    e_gid  = '0;
  endtask

  task automatic drive();
    bus.req_valid  = r_val;
    bus.sweep_busy = sweep;
    for (int i = 0; i < 3; i++) begin
      bus.req_addr[4*i +: 4]   = r_addr[i];
      bus.req_data[14*i +: 14] = r_data[i];
    end
  endtask

  task automatic tick();
    int a;
    a = (rst && !sweep) ? pick(r_val, m_last) : -1;
    m_acc = a;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else if (a >= 0) begin
      if (r_addr[a] >= 4'd1 && r_addr[a] <= 4'd12) begin
        e_wd  = {r_data[a], r_addr[a], 1'b1};
        e_err = '0;
      end else begin
        e_wd  = '0;
        e_err = onehot(a);
      end
      e_gid  = 2'(a);
      m_last = a;
    end else begin
      e_wd  = '0;
      e_err = '0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b0;
    r_val = '0;
    sweep = 1'b0;
    drive();
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    sweep = 1'b0;
    r_val = 3'b001;
    for (int i = 0; i < 3; i++) begin
      r_addr[i] = 4'd5;
      r_data[i] = 14'h1234;
    end
    model_reset();
    drive();
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (bus.write_data_1 !== 19'd0)
      $display("FAIL rst_wd got %h exp 0", bus.write_data_1);
    else n_pass++;
    n_chk++;
    if (bus.req_err !== 3'b000)
      $display("FAIL rst_err got %b exp 000", bus.req_err);
    else n_pass++;
    n_chk++;
    if (bus.grant_id !== 2'd0)
      $display("FAIL rst_gid got %0d exp 0", bus.grant_id);
    else n_pass++;
    n_chk++;
    if (bus.req_ack !== 3'b000)
      $display("FAIL rst_ack got %b exp 000", bus.req_ack);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.req_ack !== 3'b001)
      $display("FAIL first_ack got %b exp 001", bus.req_ack);
    else n_pass++;
    tick();
    n_chk++;
    if (bus.write_data_1 !== {14'h1234, 4'd5, 1'b1})
      $display("FAIL first_wd got %h exp %h", bus.write_data_1,
               {14'h1234, 4'd5, 1'b1});
    else n_pass++;
    r_val = '0;
    drive();
    #1;
    tick();
    n_chk++;
    if (bus.write_data_1 !== 19'd0)
      $display("FAIL first_wd_drop got %h exp 0", bus.write_data_1);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [2:0] ea;
    do_reset();
    r_val = 3'b111;
    for (int i = 0; i < 3; i++) begin
      r_addr[i] = 4'(i + 3);
      r_data[i] = 14'($urandom);
    end
    for (int c = 0; c < 6; c++) begin
      drive();
      #1;
      ea = onehot(c % 3);
      n_chk++;
      if (bus.req_ack !== ea)
        $display("FAIL rr_ack c=%0d got %b exp %b", c, bus.req_ack, ea);
      else n_pass++;
      tick();
      n_chk++;
      if (bus.write_data_1 !== {r_data[c%3], r_addr[c%3], 1'b1})
        $display("FAIL rr_wd c=%0d got %h exp %h", c,
                 bus.write_data_1, {r_data[c%3], r_addr[c%3], 1'b1});
      else n_pass++;
    end
    r_val = '0;
    drive();
  endtask

  task automatic test_illegal();
    logic [3:0] bad [2];
    bad[0] = 4'd0;
    bad[1] = 4'd13;
    for (int j = 0; j < 2; j++) begin
      r_val     = 3'b010;
      r_addr[1] = bad[j];
      drive();
      #1;
      n_chk++;
      if (bus.req_ack !== 3'b010)
        $display("FAIL ill_ack a=%0d got %b exp 010", bad[j], bus.req_ack);
      else n_pass++;
      r_val = '0;
      tick();
      drive();
      n_chk++;
      if (bus.req_err !== 3'b010 || bus.write_data_1 !== 19'd0)
        $display("FAIL ill_out a=%0d got err %b wd %h exp 010/0",
                 bad[j], bus.req_err, bus.write_data_1);
      else n_pass++;
      n_chk++;
      if (bus.grant_id !== 2'd1)
        $display("FAIL ill_gid got %0d exp 1", bus.grant_id);
      else n_pass++;
      #1;
      tick();
      n_chk++;
      if (bus.req_err !== 3'b000)
        $display("FAIL ill_pulse got %b exp 000", bus.req_err);
      else n_pass++;
    end
  endtask

  task automatic test_sweep();
    r_val     = 3'b100;
    r_addr[2] = 4'd7;
    r_data[2] = 14'h2abc;
    sweep     = 1'b1;
    for (int c = 0; c < 14; c++) begin
      drive();
      #1;
      n_chk++;
      if (bus.req_ack !== 3'b000 || bus.write_data_1[0] !== 1'b0)
        $display("FAIL sweep_hold c=%0d got ack %b en %b exp 000/0",
                 c, bus.req_ack, bus.write_data_1[0]);
      else n_pass++;
      tick();
    end
    sweep = 1'b0;
    drive();
    #1;
    n_chk++;
    if (bus.req_ack !== 3'b100)
      $display("FAIL sweep_fall_ack got %b exp 100", bus.req_ack);
    else n_pass++;
    tick();
    r_val = '0;
    drive();
    n_chk++;
    if (bus.write_data_1 !== {14'h2abc, 4'd7, 1'b1})
      $display("FAIL sweep_fall_wd got %h exp %h", bus.write_data_1,
               {14'h2abc, 4'd7, 1'b1});
    else n_pass++;
    r_val     = 3'b001;
    r_addr[0] = 4'd12;
    r_data[0] = 14'h0f0f;
    drive();
    #1;
    tick();
    sweep     = 1'b1;
    r_addr[0] = 4'd3;
    drive();
    #1;
    n_chk++;
    if (bus.req_ack !== 3'b000 ||
        bus.write_data_1 !== {14'h0f0f, 4'd12, 1'b1})
      $display("FAIL sweep_rise got ack %b wd %h exp 000/%h",
               bus.req_ack, bus.write_data_1, {14'h0f0f, 4'd12, 1'b1});
    else n_pass++;
    tick();
    n_chk++;
    if (bus.write_data_1 !== 19'd0)
      $display("FAIL sweep_rise_next got %h exp 0", bus.write_data_1);
    else n_pass++;
    sweep = 1'b0;
    r_val = '0;
    drive();
  endtask

  task automatic test_reset_mid();
    r_val     = 3'b001;
    r_addr[0] = 4'd9;
    r_data[0] = 14'h1111;
    drive();
    #1;
    tick();
    rst = 1'b0;
    #1;
    n_chk++;
    if (bus.write_data_1 !== 19'd0 || bus.grant_id !== 2'd0)
      $display("FAIL mid_rst got wd %h gid %0d exp 0/0",
               bus.write_data_1, bus.grant_id);
    else n_pass++;
    tick();
    rst   = 1'b1;
    r_val = '0;
    drive();
    #1;
    tick();
    n_chk++;
    if (bus.write_data_1 !== 19'd0)
      $display("FAIL mid_rst_release got %h exp 0", bus.write_data_1);
    else n_pass++;
  endtask

  task automatic test_random();
    int wait_c [3];
    logic [2:0] ea;
    for (int i = 0; i < 3; i++) wait_c[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!r_val[i] && ($urandom_range(0, 1) == 1)) begin
          r_val[i]  = 1'b1;
          r_addr[i] = 4'($urandom_range(0, 15));
          r_data[i] = 14'($urandom);
          wait_c[i] = 0;
        end
      end
      sweep = ($urandom_range(0, 99) < 15);
      drive();
      #1;
      ea = sweep ? 3'b000 : onehot(pick(r_val, m_last));
      n_chk++;
      if (bus.req_ack !== ea)
        $display("FAIL rnd_ack c=%0d got %b exp %b", c, bus.req_ack, ea);
      else n_pass++;
      for (int i = 0; i < 3; i++)
        if (r_val[i] && !sweep) wait_c[i]++;
      tick();
      n_chk++;
      if (bus.write_data_1 !== e_wd || bus.req_err !== e_err ||
          bus.grant_id !== e_gid)
        $display("FAIL rnd_out c=%0d got %h/%b/%0d exp %h/%b/%0d", c,
                 bus.write_data_1, bus.req_err, bus.grant_id,
                 e_wd, e_err, e_gid);
      else n_pass++;
      if (m_acc >= 0) begin
`ifndef REGFILE_ARB_FIXED_PRIORITY_EN
        n_chk++;
        if (wait_c[m_acc] > 3)
          $display("FAIL rnd_fair r=%0d got %0d exp <=3", m_acc,
                   wait_c[m_acc]);
        else n_pass++;
`endif
        r_val[m_acc] = 1'b0;
      end
    end
    sweep = 1'b0;
    r_val = '0;
    drive();
    #1;
    tick();
  endtask

`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
  task automatic test_fixed();
    r_val     = 3'b101;
    r_addr[0] = 4'd2;
    r_addr[2] = 4'd4;
    for (int c = 0; c < 5; c++) begin
      drive();
      #1;
      n_chk++;
      if (bus.req_ack !== 3'b001)
        $display("FAIL fix_ack c=%0d got %b exp 001", c, bus.req_ack);
      else n_pass++;
      tick();
    end
    r_val = 3'b100;
    drive();
    #1;
    n_chk++;
    if (bus.req_ack !== 3'b100)
      $display("FAIL fix_ack2 got %b exp 100", bus.req_ack);
    else n_pass++;
    tick();
    r_val = '0;
    drive();
  endtask
`endif

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_round_robin();
    test_illegal();
    test_sweep();
    test_reset_mid();
    test_random();
`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
    test_fixed();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
